// File: rtl/chacha20_block_core_if.sv
// Handshake and data bundle between the ChaCha20 block core, its block
// counter and its keystream consumer. The core uses the slave modport.
interface chacha20_block_core_if;
  logic         start_i;
  logic [255:0] key_i;
  logic [95:0]  nonce_i;
  logic [31:0]  counter_i;
  logic         ready_o;
  logic         valid_o;
  logic         ready_i;
  logic [511:0] keystream_o;
  logic         incr_o;

  modport slave (
    input  start_i, key_i, nonce_i, counter_i, ready_i,
    output ready_o, valid_o, keystream_o, incr_o
  );

  modport master (
    output start_i, key_i, nonce_i, counter_i, ready_i,
    input  ready_o, valid_o, keystream_o, incr_o
  );
endinterface

// File: rtl/chacha20_block_core.sv
// Iterative ChaCha20 block function: one full round (four parallel
// quarter-rounds, column or diagonal) per clock, then the final feed-forward
// addition of the initial state into a held 512-bit keystream register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for start_i; inputs sampled into init/working state
// ROUND | one round per edge; last round registers the keystream
// VALID | keystream held until ready_i; handshake pulses incr_o
module chacha20_block_core #(
  parameter int ROUNDS     = 20,
  parameter int ROUND_BITS = 5
) (
  input logic                  clk_i,
  input logic                  rst_i,
  chacha20_block_core_if.slave bus
);

  if ((ROUNDS < 2) || ((ROUNDS % 2) != 0) || ((2 ** ROUND_BITS) <= ROUNDS)) begin : g_bad_param
    $error("chacha20_block_core: ROUNDS must be even, >= 2 and below 2**ROUND_BITS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [ROUND_BITS-1:0] LAST_ROUND = ROUND_BITS'(ROUNDS - 1);

  function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                 input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Diagonal rounds rotate rows 1..3 left by 1..3 positions relative to the column.
  function automatic logic [15:0][31:0] one_round(input logic [15:0][31:0] s, input logic diag);
    logic [15:0][31:0] r;
    logic [3:0] ia, ib, ic, id;
    r = s;
    for (int i = 0; i < 4; i++) begin
      ia = 4'(i);
      ib = diag ? 4'(4 + ((i + 1) % 4))  : 4'(4 + i);
      ic = diag ? 4'(8 + ((i + 2) % 4))  : 4'(8 + i);
      id = diag ? 4'(12 + ((i + 3) % 4)) : 4'(12 + i);
      {r[ia], r[ib], r[ic], r[id]} = quarter_round(s[ia], s[ib], s[ic], s[id]);
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [ROUND_BITS-1:0]  round_q, round_d;
  logic [15:0][31:0]      work_q, work_d;
  logic [15:0][31:0]      init_q, init_d;
  logic [15:0][31:0]      ks_q, ks_d;
  logic                   incr_q, incr_d;
  logic [15:0][31:0]      init_state;
  logic [15:0][31:0]      round_res;

  // Word 0 sits in the low bits, so the packed concat lists word 15 first.
  assign init_state = {bus.nonce_i, bus.counter_i, bus.key_i,
                       32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  assign round_res  = one_round(work_q, round_q[0]);

  // Next-state, round datapath and keystream feed-forward.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    work_d  = work_q;
    init_d  = init_q;
    ks_d    = ks_q;
    incr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          init_d  = init_state;
          work_d  = init_state;
          round_d = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d  = round_res;
        round_d = round_q + 1'b1;
        if (round_q == LAST_ROUND) begin
          for (int k = 0; k < 16; k++) begin
            ks_d[k] = round_res[k] + init_q[k];
          end
          state_d = VALID;
        end
      end
      VALID: begin
        if (bus.ready_i) begin
          incr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      round_q <= '0;
      ks_q    <= '0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      ks_q    <= ks_d;
      incr_q  <= incr_d;
    end
  end

  // Working and initial state carry no reset; they are reloaded on every start.
  always_ff @(posedge clk_i) begin
    work_q <= work_d;
    init_q <= init_d;
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.valid_o     = (state_q == VALID);
  assign bus.keystream_o = ks_q;
  assign bus.incr_o      = incr_q;

endmodule

// File: tb/tb_chacha20_block_core.sv
// Scoreboard bench for chacha20_block_core: the driver pushes expected
// keystream blocks at start acceptance, a negedge monitor pops and compares
// when valid_o rises, and a small block counter model closes the incr loop.
module tb_chacha20_block_core;

  localparam logic [255:0] RFC_KEY = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                      32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};
  localparam logic [511:0] RFC_KS = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
                                     32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
                                     32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
                                     32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
  localparam logic [511:0] ZERO_KS0 = {448'h0, 32'h903df1a0, 32'hade0b876};
  localparam logic [511:0] ZERO_KS1 = {448'h0, 32'h7a385155, 32'hbee7079f};

  typedef struct {
    logic [511:0] ks;
    logic [15:0]  mask;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chacha20_block_core_if bus ();

  chacha20_block_core #(.ROUNDS(20), .ROUND_BITS(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int blocks = 0;
  int pushes = 0;
  int incr_cnt = 0;
  exp_t sb[$];

  logic [31:0] cnt;
  logic        cnt_load = 1'b1;
  logic [31:0] cnt_val = 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_load) cnt <= cnt_val;
    else if (bus.incr_o) cnt <= cnt + 32'd1;
    if (bus.incr_o) incr_cnt <= incr_cnt + 1;
  end
  assign bus.counter_i = cnt;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  logic         v_prev = 1'b0;
  logic         hs_prev = 1'b0;
  logic [511:0] held;

  always @(negedge clk) begin
    exp_t e;
    if (hs_prev) begin
      chk("hs_valid_low", 512'(bus.valid_o), 512'(1'b0));
      chk("hs_incr_high", 512'(bus.incr_o), 512'(1'b1));
      chk("hs_ready_high", 512'(bus.ready_o), 512'(1'b1));
    end else begin
      chk("incr_spurious", 512'(bus.incr_o), 512'(1'b0));
    end
    if (bus.valid_o && !v_prev) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_block got=%0h want=none", bus.keystream_o);
      end else begin
        e = sb.pop_front();
        blocks++;
        chk("latency", 512'(cyc - e.acc_cyc), 512'(20));
        for (int k = 0; k < 16; k++) begin
          if (e.mask[k]) chk($sformatf("ks_word%0d", k), 512'(bus.keystream_o[32*k +: 32]), 512'(e.ks[32*k +: 32]));
        end
        held = bus.keystream_o;
      end
    end else if (bus.valid_o) begin
      chk("hold_stable", bus.keystream_o, held);
    end
    hs_prev = bus.valid_o && bus.ready_i && !rst;
    v_prev  = bus.valid_o;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cnt(input logic [31:0] v);
    cnt_load = 1'b1;
    cnt_val  = v;
    tick();
    cnt_load = 1'b0;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!(bus.ready_o && !bus.incr_o) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("ready_timeout", 512'(n), 512'(0));
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!bus.valid_o && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("valid_timeout", 512'(n), 512'(0));
  endtask

  task automatic start_block(input logic [255:0] k, input logic [95:0] n, input logic push,
                             input logic [511:0] ks, input logic [15:0] mask, input logic hold_start);
    wait_ready();
    bus.key_i   = k;
    bus.nonce_i = n;
    bus.start_i = 1'b1;
    tick();
    if (push) begin
      sb.push_back('{ks, mask, cyc});
      pushes++;
    end
    if (!hold_start) bus.start_i = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 512'(bus.ready_o), 512'(1'b1));
    chk({tag, "_valid"}, 512'(bus.valid_o), 512'(1'b0));
    chk({tag, "_incr"}, 512'(bus.incr_o), 512'(1'b0));
    chk({tag, "_ks"}, bus.keystream_o, 512'(0));
  endtask

  initial begin
    int base_incr;
    int base_blk;
    bus.start_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.key_i   = '0;
    bus.nonce_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    cnt_load = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_reset_outs("idle");
    end

    // RFC 8439 2.3.2 full block, counter 1
    set_cnt(32'd1);
    base_incr = incr_cnt;
    start_block(RFC_KEY, RFC_NONCE, 1'b1, RFC_KS, 16'hffff, 1'b0);
    wait_valid();
    wait_ready();
    chk("rfc_incr_once", 512'(incr_cnt - base_incr), 512'(1));

    // consumer stalls for 10 cycles
    set_cnt(32'd1);
    bus.ready_i = 1'b0;
    base_incr = incr_cnt;
    start_block(RFC_KEY, RFC_NONCE, 1'b1, RFC_KS, 16'hffff, 1'b0);
    wait_valid();
    repeat (10) tick();
    chk("stall_valid_held", 512'(bus.valid_o), 512'(1'b1));
    chk("stall_no_incr", 512'(incr_cnt - base_incr), 512'(0));
    bus.ready_i = 1'b1;
    tick();
    wait_ready();
    chk("stall_incr_once", 512'(incr_cnt - base_incr), 512'(1));

    // start held high during ROUND is ignored
    set_cnt(32'd0);
    base_incr = incr_cnt;
    base_blk  = blocks;
    start_block('0, '0, 1'b1, ZERO_KS0, 16'h0003, 1'b1);
    wait_valid();
    bus.start_i = 1'b0;
    wait_ready();
    repeat (3) tick();
    chk("pulse_one_block", 512'(blocks - base_blk), 512'(1));
    chk("pulse_one_incr", 512'(incr_cnt - base_incr), 512'(1));
    chk("pulse_cnt_adv", 512'(cnt), 512'(1));

    // back-to-back blocks, counter advanced by incr_o
    set_cnt(32'd0);
    start_block('0, '0, 1'b1, ZERO_KS0, 16'h0003, 1'b0);
    wait_valid();
    start_block('0, '0, 1'b1, ZERO_KS1, 16'h0003, 1'b0);
    wait_valid();
    wait_ready();
    chk("b2b_cnt", 512'(cnt), 512'(2));

    // reset mid-ROUND
    set_cnt(32'd1);
    base_incr = incr_cnt;
    start_block(RFC_KEY, RFC_NONCE, 1'b0, RFC_KS, 16'hffff, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk_reset_outs("rst_round");
    rst = 1'b0;
    repeat (25) tick();
    chk("abort_no_valid", 512'(bus.valid_o), 512'(1'b0));

    // reset in VALID
    bus.ready_i = 1'b0;
    start_block(RFC_KEY, RFC_NONCE, 1'b1, RFC_KS, 16'hffff, 1'b0);
    wait_valid();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk_reset_outs("rst_valid");
    rst = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    chk("rst_no_incr", 512'(incr_cnt - base_incr), 512'(0));
    chk("rst_cnt_kept", 512'(cnt), 512'(1));

    // block after resets
    start_block(RFC_KEY, RFC_NONCE, 1'b1, RFC_KS, 16'hffff, 1'b0);
    wait_valid();
    wait_ready();
    repeat (3) tick();

    chk("sb_empty", 512'(sb.size()), 512'(0));
    chk("blocks_seen", 512'(blocks), 512'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
